// File: rtl/fann_pkg.sv
// Shared definitions for the aggregator/disaggregator pair: default geometry,
// lane-count field width and lane slicing.
package fann_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FETCH_WIDTH = 2;

  // Lane counts run 1..fetch_width inclusive, hence the extra bit.
  function automatic int cw_of(input int fetch_width);
    return $clog2(fetch_width) + 1;
  endfunction

  function automatic int lane_lo(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/disaggregator_if.sv
// Wide-side FWFT pop port and narrow-side push port of the disaggregator.
interface disaggregator_if import fann_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH
) ();

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq
  );

endinterface

// File: rtl/disaggregator_lane_shift_reg.sv
// Hold register of packed lanes plus remaining-lane count; a load wins over a
// shift so a word can be refilled in the same cycle its last lane leaves.
module lane_shift_reg import fann_pkg::*; #(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int FETCH_WIDTH = DEF_FETCH_WIDTH,
  localparam int CW          = cw_of(FETCH_WIDTH),
  localparam int HW          = FETCH_WIDTH * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [HW-1:0]         load_data_i,
  input  logic [CW-1:0]         load_count_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CW-1:0]         count_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    hold_d  = hold_q;
    count_d = count_q;
    if (load_i) begin
      hold_d  = load_data_i;
      count_d = load_count_i;
    end else if (shift_i) begin
      hold_d  = hold_q >> DATA_WIDTH;
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  assign data_o  = hold_q[DATA_WIDTH-1:0];
  assign count_o = count_q;

endmodule

// File: rtl/disaggregator.sv
// Parallel-to-serial stage: pops a packed word from an FWFT FIFO and emits its
// active lanes one per cycle, lane 0 first, with a runtime lane count.
module disaggregator import fann_pkg::*; #(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int FETCH_WIDTH = DEF_FETCH_WIDTH,
  localparam int CW          = cw_of(FETCH_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  disaggregator_if.slave       bus,
  input  logic                 change_fetch_width,
  input  logic [CW-1:0]        input_fetch_width,
  output logic                 busy
);

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FW_C = CW'(FETCH_WIDTH);

  logic [CW-1:0] count;
  logic          last_out;
  logic          req_ok;
  logic [CW-1:0] width_q, width_d;
  logic [CW-1:0] pend_w_q, pend_w_d;
  logic          pend_q, pend_d;

  lane_shift_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_lanes (
    .clk          (clk),
    .rst          (rst),
    .load_i       (bus.sender_deq),
    .shift_i      (bus.receiver_enq),
    .load_data_i  (bus.sender_data),
    .load_count_i (width_q),
    .data_o       (bus.receiver_data),
    .count_o      (count)
  );

  assign bus.receiver_enq = (count != '0) && bus.receiver_full_n;
  // True when the hold register is empty now or empties at this clock edge.
  assign last_out         = (count == '0) || ((count == ONE) && bus.receiver_enq);
  // A pending width change blocks refills so the in-flight word finishes at the old width.
  assign bus.sender_deq   = bus.sender_empty_n && !pend_q && last_out;
  assign req_ok           = (input_fetch_width != '0) && (input_fetch_width <= FW_C);
  assign busy             = (count != '0) || pend_q;

  always_comb begin
    width_d  = width_q;
    pend_d   = pend_q;
    pend_w_d = pend_w_q;
    if (pend_q && last_out) begin
      width_d = pend_w_q;
      pend_d  = 1'b0;
    end
    // A fresh request outranks the one being applied or still waiting.
    if (change_fetch_width && req_ok) begin
      pend_d   = 1'b1;
      pend_w_d = input_fetch_width;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q  <= FW_C;
      pend_q   <= 1'b0;
      pend_w_q <= FW_C;
    end else begin
      width_q  <= width_d;
      pend_q   <= pend_d;
      pend_w_q <= pend_w_d;
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Bench for disaggregator: directed vector table, a pending-width overwrite
// sequence, and randomized FIFO/backpressure traffic against a queue model.
module tb_disaggregator;
  import fann_pkg::*;

  localparam int DW = 8;
  localparam int FW = 2;
  localparam int NW = 120;

  typedef struct {
    logic        r, en;
    logic [15:0] d;
    logic        fn, cf;
    logic [1:0]  iw;
    logic        edeq, eenq, ebusy, cd;
    logic [7:0]  ed;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       change_fetch_width;
  logic [1:0] input_fetch_width;
  logic       busy;
  int         total = 0;
  int         passed = 0;
  vec_t       tbl[$];
  logic [7:0] q[$];
  int         idx = 0;

  disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus.slave),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic r, en, input logic [15:0] d, input logic fn, cf,
                     input logic [1:0] iw, input logic edeq, eenq, ebusy, cd,
                     input logic [7:0] ed);
    vec_t v;
    v.r = r; v.en = en; v.d = d; v.fn = fn; v.cf = cf; v.iw = iw;
    v.edeq = edeq; v.eenq = eenq; v.ebusy = ebusy; v.cd = cd; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, en, input logic [15:0] d, input logic fn, cf,
                       input logic [1:0] iw);
    @(negedge clk);
    rst = r; bus.sender_empty_n = en; bus.sender_data = d;
    bus.receiver_full_n = fn; change_fetch_width = cf; input_fetch_width = iw;
    #1;
  endtask

  task automatic step(input logic r, en, input logic [15:0] d, input logic fn, cf,
                      input logic [1:0] iw, input logic edeq, eenq, ebusy, cd,
                      input logic [7:0] ed, input string nm);
    drive(r, en, d, fn, cf, iw);
    chk({nm, ".deq"},  16'(bus.sender_deq),   16'(edeq));
    chk({nm, ".enq"},  16'(bus.receiver_enq), 16'(eenq));
    chk({nm, ".busy"}, 16'(busy),             16'(ebusy));
    if (cd) chk({nm, ".data"}, 16'(bus.receiver_data), 16'(ed));
  endtask

  function automatic logic [15:0] mkword(input int k);
    logic [15:0] w;
    w[lane_lo(0, DW) +: DW] = 8'(2 * k);
    w[lane_lo(1, DW) +: DW] = 8'(2 * k + 1);
    return w;
  endfunction

  // One randomized cycle: outputs predicted from the queue of lanes still owed downstream.
  task automatic rcycle(input logic en_req, input logic fn, input string nm);
    logic        en, e_enq, e_deq;
    logic [15:0] w;
    logic [7:0]  b;
    en = en_req && (idx < NW);
    w  = (idx < NW) ? mkword(idx) : 16'h0;
    drive(1'b0, en, w, fn, 1'b0, 2'd0);
    e_enq = (q.size() != 0) && fn;
    e_deq = en && ((q.size() == 0) || ((q.size() == 1) && e_enq));
    chk({nm, ".deq"},  16'(bus.sender_deq),   16'(e_deq));
    chk({nm, ".enq"},  16'(bus.receiver_enq), 16'(e_enq));
    chk({nm, ".busy"}, 16'(busy),             16'(q.size() != 0));
    if (e_enq) begin
      chk({nm, ".data"}, 16'(bus.receiver_data), 16'(q[0]));
      b = q.pop_front();
    end
    if (e_deq) begin
      for (int l = 0; l < FW; l++) q.push_back(w[lane_lo(l, DW) +: DW]);
      idx++;
    end
  endtask

  initial begin
    rst = 1'b1; bus.sender_empty_n = 1'b0; bus.sender_data = '0;
    bus.receiver_full_n = 1'b0; change_fetch_width = 1'b0; input_fetch_width = '0;
    repeat (2) @(posedge clk);

    //   r  en  data     fn cf iw   deq enq busy cd data
    add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 0, 1, 8'h00);
    add(0, 1, 16'h0100, 1, 0, 0,   1, 0, 0, 1, 8'h00);
    add(0, 1, 16'h0302, 1, 0, 0,   0, 1, 1, 1, 8'h00);
    add(0, 1, 16'h0302, 1, 0, 0,   1, 1, 1, 1, 8'h01);
    add(0, 1, 16'h0504, 1, 0, 0,   0, 1, 1, 1, 8'h02);
    for (int i = 0; i < 3; i++)
      add(0, 1, 16'h0504, 0, 0, 0, 0, 0, 1, 1, 8'h03);
    add(0, 1, 16'h0504, 1, 0, 0,   1, 1, 1, 1, 8'h03);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h04);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h05);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 0, 1, 8'h00);
    add(0, 1, 16'h0908, 1, 0, 0,   1, 0, 0, 1, 8'h00);
    add(0, 1, 16'h0706, 1, 1, 1,   0, 1, 1, 1, 8'h08);
    add(0, 1, 16'h0706, 1, 0, 0,   0, 1, 1, 1, 8'h09);
    add(0, 1, 16'h0706, 1, 0, 0,   1, 0, 0, 1, 8'h00);
    add(0, 1, 16'h0B0A, 1, 0, 0,   1, 1, 1, 1, 8'h06);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h0A);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 0, 0, 8'h00);
    add(0, 1, 16'h1110, 1, 0, 0,   1, 0, 0, 0, 8'h00);
    add(1, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h10);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 0, 1, 8'h00);
    add(0, 1, 16'h1312, 1, 0, 0,   1, 0, 0, 1, 8'h00);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h12);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h13);
    add(0, 0, 16'h0000, 1, 1, 0,   0, 0, 0, 1, 8'h00);
    add(0, 0, 16'h0000, 1, 1, 3,   0, 0, 0, 1, 8'h00);
    add(0, 1, 16'h1514, 1, 0, 0,   1, 0, 0, 1, 8'h00);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h14);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 1, 1, 1, 8'h15);
    add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 0, 1, 8'h00);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].en, tbl[i].d, tbl[i].fn, tbl[i].cf, tbl[i].iw,
           tbl[i].edeq, tbl[i].eenq, tbl[i].ebusy, tbl[i].cd, tbl[i].ed,
           $sformatf("vec%0d", i));

    // Width 1 requested then overwritten by width 2 while the word is stalled.
    step(0, 1, 16'h1716, 1, 0, 0, 1, 0, 0, 1, 8'h00, "ovr0");
    step(0, 1, 16'h1716, 0, 1, 1, 0, 0, 1, 1, 8'h16, "ovr1");
    step(0, 1, 16'h1716, 0, 1, 2, 0, 0, 1, 1, 8'h16, "ovr2");
    step(0, 1, 16'h1716, 1, 0, 0, 0, 1, 1, 1, 8'h16, "ovr3");
    step(0, 1, 16'h1716, 1, 0, 0, 0, 1, 1, 1, 8'h17, "ovr4");
    step(0, 1, 16'h1918, 1, 0, 0, 1, 0, 0, 1, 8'h00, "ovr5");
    step(0, 1, 16'h1B1A, 1, 0, 0, 0, 1, 1, 1, 8'h18, "ovr6");
    step(0, 1, 16'h1B1A, 1, 0, 0, 1, 1, 1, 1, 8'h19, "ovr7");
    step(0, 0, 16'h0000, 1, 0, 0, 0, 1, 1, 1, 8'h1A, "ovr8");
    step(0, 0, 16'h0000, 1, 0, 0, 0, 1, 1, 1, 8'h1B, "ovr9");
    step(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 8'h00, "ovr10");

    // Randomized bursty source and sink at width 2, starting from reset.
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 2'd0);
    for (int c = 0; c < 200; c++)
      rcycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $sformatf("rnd%0d", c));
    for (int c = 0; c < 4; c++)
      rcycle(1'b0, 1'b1, $sformatf("drain%0d", c));
    chk("rnd.words_popped_nonzero", 16'(idx > 0), 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
